// File: rtl/clock_switch_pkg.sv
// Shared definitions for the CPU clock-switch initiator: state encoding and counter width.
package clock_switch_pkg;

  localparam int CSW_CNT_W = 8;

  typedef enum logic [1:0] {
    CSW_HS_RUN = 2'd0,
    CSW_TO_LS  = 2'd1,
    CSW_LS_RUN = 2'd2,
    CSW_TO_HS  = 2'd3
  } csw_state_t;

endpackage

// File: rtl/sync_bit_m.sv
// Multi-flop synchronizer for one asynchronous status bit; the chain resets to 0.
module sync_bit_m #(
  parameter int STAGES = 2
) (
  input  logic ck_ip,
  input  logic reset_ip,
  input  logic d_ip,
  output logic q_op
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge ck_ip) begin
    if (reset_ip) chain <= '0;
    else          chain <= {chain[STAGES-2:0], d_ip};
  end

  assign q_op = chain[STAGES-1];

endmodule

// File: rtl/clock_switch_ctrl_m.sv
// Initiator side of the clock_switch_m handshake: picks HS/LS clock from the address decode
// and stalls the 65816 through RDY while a clock change is in flight.
module clock_switch_ctrl_m
  import clock_switch_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_LS_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       ck_ip,
  input  logic       reset_ip,
  input  logic       hs_allow_ip,
  input  logic       valid_ip,
  input  logic       slow_req_ip,
  input  logic       selected_hs_ip,
  input  logic       selected_ls_ip,
  output logic       select_hs_op,
  output logic       rdy_op,
  output logic       hs_active_op,
  output logic       timeout_err_op,
  output csw_state_t dbg_state_op
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (HOLD_LS_CYCLES < 1 || HOLD_LS_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_LS_CYCLES must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  localparam logic [CSW_CNT_W-1:0] HOLD_RLD = CSW_CNT_W'(HOLD_LS_CYCLES);
  localparam logic [CSW_CNT_W-1:0] TMO_MAX  = CSW_CNT_W'(TIMEOUT_CYCLES);

  csw_state_t           state_q, state_d;
  logic [CSW_CNT_W-1:0] hold_q, hold_d;
  logic [CSW_CNT_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic                 err_q, err_d;
  logic                 hs_active_q;
  logic                 sync_hs, sync_ls, hs_ok, ls_ok;
  logic                 slow, fast, tmo_hit, in_switch;

  sync_bit_m #(.STAGES(SYNC_STAGES)) u_sync_hs (
    .ck_ip    (ck_ip),
    .reset_ip (reset_ip),
    .d_ip     (selected_hs_ip),
    .q_op     (sync_hs)
  );

  sync_bit_m #(.STAGES(SYNC_STAGES)) u_sync_ls (
    .ck_ip    (ck_ip),
    .reset_ip (reset_ip),
    .d_ip     (selected_ls_ip),
    .q_op     (sync_ls)
  );

  // Both status bits low (or both high) mean the switch is between clocks: neither is ok.
  assign hs_ok     = sync_hs & ~sync_ls;
  assign ls_ok     = sync_ls & ~sync_hs;
  assign slow      = valid_ip & slow_req_ip;
  assign fast      = valid_ip & ~slow_req_ip;
  assign in_switch = (state_q == CSW_TO_LS) || (state_q == CSW_TO_HS);
  assign tmo_inc   = tmo_q + 1'b1;
  assign tmo_hit   = (tmo_inc == TMO_MAX);

  always_ff @(posedge ck_ip) begin
    if (reset_ip) begin
      state_q     <= CSW_LS_RUN;
      hold_q      <= HOLD_RLD;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      hs_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      hs_active_q <= (state_d == CSW_HS_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      CSW_HS_RUN: if (slow || !hs_allow_ip) state_d = CSW_TO_LS;
      CSW_TO_LS: begin
        if (ls_ok) begin
          state_d = CSW_LS_RUN;
        end else if (tmo_hit) begin
          state_d = CSW_LS_RUN;
          err_d   = 1'b1;
        end
      end
      // A latched timeout blocks any further HS request until reset.
      CSW_LS_RUN: if (hold_q == '0 && hs_allow_ip && !slow && !err_q) state_d = CSW_TO_HS;
      CSW_TO_HS: begin
        if (hs_ok && hs_allow_ip) begin
          state_d = CSW_HS_RUN;
        end else if (tmo_hit) begin
          state_d = CSW_TO_LS;
          err_d   = 1'b1;
        end else if (!hs_allow_ip) begin
          state_d = CSW_TO_LS;
        end
      end
      default: state_d = CSW_LS_RUN;
    endcase

    if (state_d != state_q) tmo_d = '0;
    else if (in_switch)     tmo_d = tmo_inc;
    else                    tmo_d = tmo_q;

    hold_d = hold_q;
    if (state_d == CSW_LS_RUN && state_q != CSW_LS_RUN) hold_d = HOLD_RLD;
    else if (state_q == CSW_LS_RUN && slow)             hold_d = HOLD_RLD;
    else if (state_q == CSW_LS_RUN && fast && hold_q != '0) hold_d = hold_q - 1'b1;
  end

  // select_hs_op is the request to the switch; rdy_op stays low until the synchronized status
  // confirms the requested clock, and drops in the same cycle as a slow access seen in HS_RUN.
  always_comb begin
    select_hs_op = 1'b0;
    rdy_op       = 1'b1;
    case (state_q)
      CSW_HS_RUN: begin select_hs_op = 1'b1; rdy_op = ~slow; end
      CSW_TO_LS:  begin select_hs_op = 1'b0; rdy_op = 1'b0;  end
      CSW_LS_RUN: begin select_hs_op = 1'b0; rdy_op = 1'b1;  end
      CSW_TO_HS:  begin select_hs_op = 1'b1; rdy_op = 1'b0;  end
      default:    begin select_hs_op = 1'b0; rdy_op = 1'b1;  end
    endcase
  end

  assign hs_active_op   = hs_active_q;
  assign timeout_err_op = err_q;
  assign dbg_state_op   = state_q;

endmodule

// File: tb/tb_clock_switch_ctrl_m.sv
// Bench for clock_switch_ctrl_m with a behavioural stand-in for clock_switch_m and a cycle model.
module tb_clock_switch_ctrl_m;
  import clock_switch_pkg::*;

  localparam int SYNC = 2;
  localparam int HOLD = 4;
  localparam int TMO  = 255;

  logic       ck_ip = 1'b0;
  logic       reset_ip = 1'b1;
  logic       hs_allow_ip = 1'b1;
  logic       valid_ip = 1'b0;
  logic       slow_req_ip = 1'b0;
  logic       selected_hs_ip = 1'b0;
  logic       selected_ls_ip = 1'b1;
  logic       select_hs_op, rdy_op, hs_active_op, timeout_err_op;
  csw_state_t dbg_state_op;

  int checks = 0;
  int failures = 0;

  clock_switch_ctrl_m #(
    .SYNC_STAGES    (SYNC),
    .HOLD_LS_CYCLES (HOLD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .ck_ip          (ck_ip),
    .reset_ip       (reset_ip),
    .hs_allow_ip    (hs_allow_ip),
    .valid_ip       (valid_ip),
    .slow_req_ip    (slow_req_ip),
    .selected_hs_ip (selected_hs_ip),
    .selected_ls_ip (selected_ls_ip),
    .select_hs_op   (select_hs_op),
    .rdy_op         (rdy_op),
    .hs_active_op   (hs_active_op),
    .timeout_err_op (timeout_err_op),
    .dbg_state_op   (dbg_state_op)
  );

  // ---------------- clock / reset ----------------
  always #5 ck_ip = ~ck_ip;

  // ---------------- switch stand-in: break-before-make, random settle time ----------------
  bit   tie_zero = 1'b0;
  logic sw_tgt = 1'b0;
  int   sw_cnt = 0;

  always @(negedge ck_ip) begin
    if (tie_zero) begin
      selected_hs_ip <= 1'b0;
      selected_ls_ip <= 1'b0;
    end else if (select_hs_op !== sw_tgt) begin
      sw_tgt         <= select_hs_op;
      selected_hs_ip <= 1'b0;
      selected_ls_ip <= 1'b0;
      sw_cnt         <= $urandom_range(1, 3);
    end else if (sw_cnt > 1) begin
      sw_cnt <= sw_cnt - 1;
    end else begin
      sw_cnt         <= 0;
      selected_hs_ip <= sw_tgt;
      selected_ls_ip <= ~sw_tgt;
    end
  end

  // ---------------- reference model ----------------
  csw_state_t m_state = CSW_LS_RUN;
  int         m_hold = HOLD;
  int         m_wait = 0;
  bit         m_err = 1'b0;
  logic [1:0] hist_q[$];        // raw {hs,ls} seen at recent edges; [0] is what the DUT sees now
  logic [5:0] obs_vec, exp_vec; // {state, select_hs, rdy, hs_active, timeout_err}

  task automatic model_enter(input csw_state_t s);
    m_state = s;
    m_wait  = 0;
    if (s == CSW_LS_RUN) m_hold = HOLD;
  endtask

  task automatic model_step(input bit rst, input bit v, input bit s, input bit a,
                            input logic [1:0] raw);
    bit slow_c, fast_c, hs_ok, ls_ok, timed;
    if (rst) begin
      m_state = CSW_LS_RUN; m_hold = HOLD; m_wait = 0; m_err = 1'b0;
      hist_q = {};
      for (int i = 0; i < SYNC; i++) hist_q.push_back(2'b00);
      return;
    end
    slow_c = v && s;
    fast_c = v && !s;
    hs_ok  = (hist_q[0] == 2'b10);
    ls_ok  = (hist_q[0] == 2'b01);
    timed  = (m_wait + 1 == TMO);
    case (m_state)
      CSW_HS_RUN: if (slow_c || !a) model_enter(CSW_TO_LS);
      CSW_TO_LS: begin
        if (ls_ok) model_enter(CSW_LS_RUN);
        else if (timed) begin m_err = 1'b1; model_enter(CSW_LS_RUN); end
        else m_wait++;
      end
      CSW_LS_RUN: begin
        if (m_hold == 0 && a && !slow_c && !m_err) model_enter(CSW_TO_HS);
        else if (slow_c) m_hold = HOLD;
        else if (fast_c && m_hold > 0) m_hold--;
      end
      default: begin
        if (hs_ok && a) model_enter(CSW_HS_RUN);
        else if (timed) begin m_err = 1'b1; model_enter(CSW_TO_LS); end
        else if (!a) model_enter(CSW_TO_LS);
        else m_wait++;
      end
    endcase
    hist_q.push_back(raw);
    void'(hist_q.pop_front());
  endtask

  // ---------------- driver: one CPU cycle, outputs captured mid-cycle ----------------
  task automatic drive_cycle(input bit rst, input bit v, input bit s, input bit a);
    logic [1:0] raw;
    bit e_sel, e_rdy, e_hsa;
    reset_ip = rst; valid_ip = v; slow_req_ip = s; hs_allow_ip = a;
    @(negedge ck_ip); #1;
    e_sel   = (m_state == CSW_HS_RUN) || (m_state == CSW_TO_HS);
    e_rdy   = (m_state == CSW_LS_RUN) || (m_state == CSW_HS_RUN && !(v && s));
    e_hsa   = (m_state == CSW_HS_RUN);
    exp_vec = {m_state, e_sel, e_rdy, e_hsa, m_err};
    obs_vec = {dbg_state_op, select_hs_op, rdy_op, hs_active_op, timeout_err_op};
    raw     = {selected_hs_ip, selected_ls_ip};
    @(posedge ck_ip); #1;
    model_step(rst, v, s, a, raw);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    drive_cycle(1, 0, 0, 1);
    drive_cycle(1, 0, 0, 1);
    drive_cycle(0, 0, 0, 1);
    checks++;
    if (obs_vec !== {CSW_LS_RUN, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", obs_vec, {CSW_LS_RUN, 4'b0100});
    end
    for (int i = 0; i < 6; i++) begin
      drive_cycle(0, 0, 0, 1);
      checks++;
      if (obs_vec !== exp_vec || obs_vec[5:4] !== CSW_LS_RUN) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_up_to_hs;
    bit saw_stall = 1'b0;
    bit reached = 1'b0;
    for (int i = 0; i < 30 && !reached; i++) begin
      drive_cycle(0, 1, 0, 1);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL up_to_hs cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
      if (obs_vec[5:4] == CSW_TO_HS && obs_vec[2] == 1'b0) saw_stall = 1'b1;
      if (obs_vec[5:4] == CSW_HS_RUN) reached = 1'b1;
    end
    checks++;
    if (!reached || !saw_stall || obs_vec[3:0] !== 4'b1110) begin
      failures++;
      $display("FAIL up_to_hs_final reached=%0d stall=%0d outs=%b want=1110", reached, saw_stall, obs_vec[3:0]);
    end
  endtask

  task automatic test_slow_from_hs;
    int stall = 0;
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      drive_cycle(0, 1, 1, 1);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL slow_from_hs cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
      if (i == 0 && obs_vec[2] !== 1'b0) begin
        failures++;
        $display("FAIL slow_same_cycle_stall rdy=%b want=0", obs_vec[2]);
      end
      if (obs_vec[2] == 1'b0) stall++;
      else done = 1'b1;
    end
    checks++;
    if (!done || stall < SYNC + 1 || obs_vec[5:4] !== CSW_LS_RUN) begin
      failures++;
      $display("FAIL slow_stall_len stall=%0d want>=%0d done=%0d", stall, SYNC + 1, done);
    end
  endtask

  task automatic test_ls_hold;
    for (int i = 0; i < 30; i++) begin
      drive_cycle(0, 1, (i % 3) == 2, 1);
      checks++;
      if (obs_vec !== exp_vec || obs_vec[5:4] !== CSW_LS_RUN) begin
        failures++;
        $display("FAIL ls_hold cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
    end
    // Four fast cycles drain the counter; a slow access in the cycle it reads 0 must reload it.
    for (int i = 0; i < 9; i++) begin
      drive_cycle(0, 1, i == 4, 1);
      checks++;
      if (obs_vec !== exp_vec || obs_vec[5:4] !== CSW_LS_RUN) begin
        failures++;
        $display("FAIL ls_hold_reload cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_allow_drop;
    bit saw_hsa = 1'b0;
    bit back = 1'b0;
    for (int i = 0; i < 20 && m_state != CSW_TO_HS; i++) drive_cycle(0, 1, 0, 1);
    checks++;
    if (m_state != CSW_TO_HS) begin
      failures++;
      $display("FAIL allow_drop_setup state=%0d want=%0d", m_state, CSW_TO_HS);
    end
    drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 1, 0, 0);
    checks++;
    if (obs_vec !== exp_vec || obs_vec[5:3] !== {CSW_TO_LS, 1'b0}) begin
      failures++;
      $display("FAIL allow_drop_to_ls got=%b want=%b", obs_vec, exp_vec);
    end
    for (int i = 0; i < 40 && !back; i++) begin
      drive_cycle(0, 1, 0, 0);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL allow_drop cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
      if (obs_vec[1]) saw_hsa = 1'b1;
      if (obs_vec[5:4] == CSW_LS_RUN) back = 1'b1;
    end
    checks++;
    if (!back || saw_hsa) begin
      failures++;
      $display("FAIL allow_drop_final back_in_ls=%0d hs_active_seen=%0d want 1/0", back, saw_hsa);
    end
  endtask

  task automatic test_timeout;
    int stall = 0;
    bit done = 1'b0;
    bit saw_to_hs = 1'b0;
    for (int i = 0; i < 30 && m_state != CSW_HS_RUN; i++) drive_cycle(0, 1, 0, 1);
    tie_zero = 1'b1;
    drive_cycle(0, 1, 1, 1);
    checks++;
    if (obs_vec !== exp_vec || obs_vec[5:4] !== CSW_HS_RUN) begin
      failures++;
      $display("FAIL timeout_setup got=%b want=%b", obs_vec, exp_vec);
    end
    // Count the stall cycles that follow the slow cycle itself, i.e. the TO_LS dwell.
    for (int i = 0; i < 300 && !done; i++) begin
      drive_cycle(0, 1, 1, 1);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL timeout cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
      if (obs_vec[2] == 1'b0) stall++;
      else done = 1'b1;
    end
    checks++;
    if (!done || stall != TMO || obs_vec !== {CSW_LS_RUN, 4'b0101}) begin
      failures++;
      $display("FAIL timeout_len stall=%0d want=%0d outs=%b", stall, TMO, obs_vec);
    end
    tie_zero = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(0, 1, 0, 1);
      if (obs_vec[5:4] == CSW_TO_HS) saw_to_hs = 1'b1;
    end
    checks++;
    if (saw_to_hs || obs_vec !== exp_vec) begin
      failures++;
      $display("FAIL timeout_blocks_hs saw_to_hs=%0d got=%b want=%b", saw_to_hs, obs_vec, exp_vec);
    end
  endtask

  task automatic test_reset_mid_switch;
    drive_cycle(1, 0, 0, 1);
    drive_cycle(0, 0, 0, 1);
    checks++;
    if (obs_vec !== {CSW_LS_RUN, 4'b0100}) begin
      failures++;
      $display("FAIL reset_clears_err got=%b want=%b", obs_vec, {CSW_LS_RUN, 4'b0100});
    end
    for (int i = 0; i < 20 && m_state != CSW_TO_HS; i++) drive_cycle(0, 1, 0, 1);
    drive_cycle(1, 1, 0, 1);
    drive_cycle(0, 0, 0, 1);
    checks++;
    if (obs_vec !== {CSW_LS_RUN, 4'b0100}) begin
      failures++;
      $display("FAIL reset_in_to_hs got=%b want=%b", obs_vec, {CSW_LS_RUN, 4'b0100});
    end
    for (int i = 0; i < 40 && m_state != CSW_HS_RUN; i++) drive_cycle(0, 1, 0, 1);
    drive_cycle(0, 1, 1, 1);
    checks++;
    if (m_state != CSW_TO_LS || obs_vec !== exp_vec) begin
      failures++;
      $display("FAIL reset_to_ls_setup got=%b want=%b", obs_vec, exp_vec);
    end
    drive_cycle(1, 1, 1, 1);
    drive_cycle(0, 0, 0, 1);
    checks++;
    if (obs_vec !== {CSW_LS_RUN, 4'b0100}) begin
      failures++;
      $display("FAIL reset_in_to_ls got=%b want=%b", obs_vec, {CSW_LS_RUN, 4'b0100});
    end
  endtask

  task automatic test_random;
    bit v, s, a;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 24) != 0);
      drive_cycle(0, v, s, a);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL random cyc=%0d in=%b%b%b got=%b want=%b", i, v, s, a, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    @(posedge ck_ip); #1;
    test_reset;
    test_up_to_hs;
    test_slow_from_hs;
    test_ls_hold;
    test_allow_drop;
    test_timeout;
    test_reset_mid_switch;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
